// File: rtl/divisor_secuencial_param.sv
// rtl/divisor_secuencial_param.sv - sequential restoring divider with div-by-zero flag, BUSY and DONE hold
// Optional two's-complement operands when DIV_SIGNED_EN is defined.
module divisor_secuencial_param #(
  parameter int WIDTH     = 8,
  parameter int DONE_HOLD = 31
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ADD   = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  logic [2:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic [HW-1:0]    hold;

  logic [WIDTH:0]   a_shift_sub;
  logic [WIDTH:0]   a_restore;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  assign a_shift_sub = {a[WIDTH-1:0], q[WIDTH-1]} - {1'b0, m};
  assign a_restore   = a + {1'b0, m};

  // Final iteration result as it will look after the current CHECK/ADD edge.
  always_comb begin
    q_raw = {q[WIDTH-1:1], 1'b1};
    r_raw = a[WIDTH-1:0];
    if (state == S_ADD) begin
      q_raw = {q[WIDTH-1:1], 1'b0};
      r_raw = a_restore[WIDTH-1:0];
    end
  end

`ifdef DIV_SIGNED_EN
  logic sign_dd;
  logic sign_dv;

  assign dividend_mag = DIVIDEND[WIDTH-1] ? -DIVIDEND : DIVIDEND;
  assign divisor_mag  = DIVISOR[WIDTH-1]  ? -DIVISOR  : DIVISOR;
  assign q_out        = (sign_dd ^ sign_dv) ? -q_raw : q_raw;
  assign r_out        = sign_dd ? -r_raw : r_raw;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sign_dd <= 1'b0;
      sign_dv <= 1'b0;
    end else if (state == S_LOAD) begin
      sign_dd <= DIVIDEND[WIDTH-1];
      sign_dv <= DIVISOR[WIDTH-1];
    end
  end
`else
  assign dividend_mag = DIVIDEND;
  assign divisor_mag  = DIVISOR;
  assign q_out        = q_raw;
  assign r_out        = r_raw;
`endif

  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_END);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      hold      <= '0;
      DIV0      <= 1'b0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hold <= '0;
          if (START) state <= S_LOAD;
        end
        S_LOAD: begin
          a    <= '0;
          q    <= dividend_mag;
          m    <= divisor_mag;
          cnt  <= CW'(WIDTH);
          hold <= '0;
          DIV0 <= 1'b0;
          if (DIVISOR == '0) begin
            DIV0      <= 1'b1;
            QUOTIENT  <= '1;
            REMAINDER <= DIVIDEND;
            state     <= S_END;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a     <= a_shift_sub;
          q     <= {q[WIDTH-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (a[WIDTH]) begin
            state <= S_ADD;
          end else begin
            q[0] <= 1'b1;
            if (cnt == '0) begin
              QUOTIENT  <= q_out;
              REMAINDER <= r_out;
              state     <= S_END;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_ADD: begin
          a    <= a_restore;
          q[0] <= 1'b0;
          if (cnt == '0) begin
            QUOTIENT  <= q_out;
            REMAINDER <= r_out;
            state     <= S_END;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_END: begin
          if (hold == HW'(DONE_HOLD - 1)) state <= S_IDLE;
          else hold <= hold + HW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial_param.sv
// tb/tb_divisor_secuencial_param.sv - self-checking bench for divisor_secuencial_param
// Covers the default build and, when DIV_SIGNED_EN is defined, the signed build.
module tb_divisor_secuencial_param;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [7:0] DIVIDEND = '0;
  logic [7:0] DIVISOR = '0;
  logic       BUSY;
  logic       DONE;
  logic       DIV0;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  divisor_secuencial_param #(.WIDTH(8), .DONE_HOLD(31)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER)
  );

  // Reference: plain integer division; latency 1 + 2*8 + number of zero quotient-magnitude bits.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output int lat);
    int sa, sb, qi, ri, mag;
`ifdef DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      lat = 1;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      q = qi[7:0];
      r = ri[7:0];
      mag = (qi < 0) ? -qi : qi;
      lat = 1 + 16 + (8 - $countones(mag[7:0]));
    end
  endfunction

  // Runs one division from #1 after a rising edge; optionally pulses START mid-run and in S_END.
  task automatic run_check(input string name, input logic [7:0] a, input logic [7:0] b, input int pulse_at);
    logic [7:0] eq, er;
    int el, k, h;
    bit stable;
    model(a, b, eq, er, el);
    DIVIDEND = a;
    DIVISOR = b;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    k = 0;
    while (DONE !== 1'b1 && k < 100) begin
      if (pulse_at >= 0 && k == pulse_at) begin
        START = 1'b1; DIVIDEND = 8'd1; DIVISOR = 8'd1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
    end
    START = 1'b0;
    total++;
    if (k !== el) begin
      bad++;
      $display("FAIL %s latency: got=%0d exp=%0d", name, k, el);
    end
    total++;
    if ({QUOTIENT, REMAINDER, DIV0, BUSY} !== {eq, er, (b == 8'd0), 1'b1}) begin
      bad++;
      $display("FAIL %s result: got q=%0h r=%0h div0=%0b busy=%0b exp q=%0h r=%0h div0=%0b busy=1",
               name, QUOTIENT, REMAINDER, DIV0, BUSY, eq, er, (b == 8'd0));
    end
    h = 0;
    stable = 1'b1;
    while (DONE === 1'b1 && h < 100) begin
      if (QUOTIENT !== eq || REMAINDER !== er || BUSY !== 1'b1) stable = 1'b0;
      START = (pulse_at >= 0 && h == 5);
      @(posedge CLK); #1;
      h++;
    end
    START = 1'b0;
    total++;
    if (h !== 31 || !stable || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL %s done_hold: got cycles=%0d stable=%0b busy_after=%0b exp cycles=31 stable=1 busy_after=0",
               name, h, stable, BUSY);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({BUSY, DONE, DIV0, QUOTIENT, REMAINDER} !== 19'd0) begin
      bad++;
      $display("FAIL reset: got busy=%0b done=%0b div0=%0b q=%0h r=%0h exp all 0",
               BUSY, DONE, DIV0, QUOTIENT, REMAINDER);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    run_check("d_100_7", 8'd100, 8'd7, -1);
    run_check("d_255_1", 8'd255, 8'd1, -1);
    run_check("d_3_200", 8'd3, 8'd200, -1);
    run_check("d_55_0", 8'd55, 8'd0, -1);
    run_check("d_neg100_7", 8'h9C, 8'd7, -1);
    run_check("d_128_ff", 8'h80, 8'hFF, -1);
    run_check("d_0_9", 8'd0, 8'd9, -1);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      run_check($sformatf("rand_%0d", i), a, b, -1);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    run_check("b2b_pulsed", 8'd100, 8'd7, 6);
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (BUSY !== 1'b0 || QUOTIENT !== 8'd14 || REMAINDER !== 8'd2) begin
      bad++;
      $display("FAIL b2b_ignored: got busy=%0b q=%0d r=%0d exp busy=0 q=14 r=2", BUSY, QUOTIENT, REMAINDER);
    end
    DIVIDEND = 8'd9;
    DIVISOR = 8'd3;
    START = 1'b1;
    k = 0;
    while (DONE !== 1'b1 && k < 100) begin @(posedge CLK); #1; k++; end
    while (DONE === 1'b1 && k < 200) begin @(posedge CLK); #1; k++; end
    total++;
    if (BUSY !== 1'b0 || k >= 200) begin
      bad++;
      $display("FAIL b2b_held_idle: got busy=%0b cycles=%0d exp busy=0", BUSY, k);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL b2b_held_reload: got busy=%0b exp 1", BUSY);
    end
    k = 0;
    while (DONE !== 1'b1 && k < 100) begin @(posedge CLK); #1; k++; end
    while (DONE === 1'b1 && k < 200) begin @(posedge CLK); #1; k++; end
    total++;
    if (QUOTIENT !== 8'd3 || REMAINDER !== 8'd0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL b2b_held_result: got q=%0d r=%0d busy=%0b exp q=3 r=0 busy=0", QUOTIENT, REMAINDER, BUSY);
    end
  endtask

  task automatic test_reset_mid();
    DIVIDEND = 8'd100;
    DIVISOR = 8'd7;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    total++;
    if ({BUSY, DONE, DIV0, QUOTIENT, REMAINDER} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%0b done=%0b div0=%0b q=%0h r=%0h exp all 0",
               BUSY, DONE, DIV0, QUOTIENT, REMAINDER);
    end
    run_check("after_reset_9_3", 8'd9, 8'd3, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
